axil_cfg_regfile: RTL and testbench

AXIL_CFG_REGFILE -- requirements
Module: axil_cfg_regfile

---
 rtl/axil_cfg_regfile.sv | 208 ++++++++++++++++++++
 tb/tb_axil_cfg_regfile.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_regfile.sv
// AXI4-Lite configuration register file.
// Holds NUM_REGS read/write config words, followed by a read-only ID word and a
// live status word. Register 0 bit 0 is a self-clearing start strobe.
module axil_cfg_regfile #(
   parameter int          NUM_REGS = 4,
   parameter int          DATA_W   = 32,
   parameter logic [31:0] ID_VALUE = 32'hCAFEBABE
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                s_axi_aw_addr,
   input  logic                       s_axi_aw_valid,
   output logic                       s_axi_aw_ready,
   input  logic [DATA_W-1:0]          s_axi_w_data,
   input  logic [DATA_W/8-1:0]        s_axi_w_strb,
   input  logic                       s_axi_w_valid,
   output logic                       s_axi_w_ready,
   output logic [1:0]                 s_axi_b_resp,
   output logic                       s_axi_b_valid,
   input  logic                       s_axi_b_ready,
   input  logic [31:0]                s_axi_ar_addr,
   input  logic                       s_axi_ar_valid,
   output logic                       s_axi_ar_ready,
   output logic [DATA_W-1:0]          s_axi_r_data,
   output logic [1:0]                 s_axi_r_resp,
   output logic                       s_axi_r_valid,
   input  logic                       s_axi_r_ready,
   output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
   output logic                       cfg_start,
   input  logic [DATA_W-1:0]          status_in
);

   localparam int         STRB_W   = DATA_W / 8;
   localparam int         ADDR_LSB = (DATA_W == 64) ? 3 : 2;
   localparam logic [3:0] ID_IDX   = 4'(NUM_REGS);
   localparam logic [3:0] STAT_IDX = 4'(NUM_REGS + 1);
   localparam logic [1:0] RESP_OK  = 2'b00;
   localparam logic [1:0] RESP_ERR = 2'b10;

   // Write-side holders and response state
   logic                 r_aw_full;
   logic [3:0]           r_aw_idx;
   logic                 r_w_full;
   logic [DATA_W-1:0]    r_w_data;
   logic [STRB_W-1:0]    r_w_strb;
   logic                 r_b_valid;
   logic [1:0]           r_b_resp;
   logic                 r_cfg_start;

   // Read-side state
   logic                 r_r_valid;
   logic [DATA_W-1:0]    r_r_data;
   logic [1:0]           r_r_resp;

   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_ar_hs;
   logic                 w_commit;
   logic                 w_use_held;
   logic [3:0]           w_cm_idx;
   logic [DATA_W-1:0]    w_cm_data;
   logic [STRB_W-1:0]    w_cm_strb;
   logic                 w_cm_rw;
   logic                 w_start_hit;
   logic [3:0]           w_ar_idx;
   logic [DATA_W-1:0]    w_rd_data;
   logic [1:0]           w_rd_resp;
   logic [NUM_REGS*DATA_W-1:0] w_cfg_flat;
   logic                 w_unused;

   // Holders refuse new beats while a write response is outstanding.
   assign s_axi_aw_ready = !rst && !r_aw_full && !r_b_valid;
   assign s_axi_w_ready  = !rst && !r_w_full && !r_b_valid;
   assign s_axi_ar_ready = !r_r_valid;

   assign w_aw_hs = s_axi_aw_valid && s_axi_aw_ready;
   assign w_w_hs  = s_axi_w_valid && s_axi_w_ready;
   assign w_ar_hs = s_axi_ar_valid && s_axi_ar_ready;

   // Commit either from both holders, or straight from both channels when they
   // handshake together; a half-held pair commits the cycle after it completes.
   assign w_use_held  = r_aw_full && r_w_full;
   assign w_commit    = w_use_held || (w_aw_hs && w_w_hs);
   assign w_cm_idx    = w_use_held ? r_aw_idx : s_axi_aw_addr[ADDR_LSB +: 4];
   assign w_cm_data   = w_use_held ? r_w_data : s_axi_w_data;
   assign w_cm_strb   = w_use_held ? r_w_strb : s_axi_w_strb;
   assign w_cm_rw     = (w_cm_idx < ID_IDX);
   assign w_start_hit = w_commit && (w_cm_idx == 4'd0) && w_cm_strb[0] && w_cm_data[0];

   assign w_ar_idx = s_axi_ar_addr[ADDR_LSB +: 4];

   // Address bits above and below the register index are intentionally ignored.
   assign w_unused = &{1'b0, s_axi_aw_addr[31:ADDR_LSB+4], s_axi_aw_addr[ADDR_LSB-1:0],
                       s_axi_ar_addr[31:ADDR_LSB+4], s_axi_ar_addr[ADDR_LSB-1:0]};

   // Config registers: byte-enabled update on commit; reg 0 bit 0 never stores.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
      logic [DATA_W-1:0] r_val;
      logic [DATA_W-1:0] w_merged;

      // Merge strobed bytes of the committing beat over the current value
      always_comb begin
         w_merged = r_val;
         for (int k = 0; k < STRB_W; k++) begin
            if (w_cm_strb[k]) begin
               w_merged[k*8 +: 8] = w_cm_data[k*8 +: 8];
            end
         end
         if (gi == 0) begin
            w_merged[0] = 1'b0;
         end
      end

      // Register update on a commit addressed to this index
      always_ff @(posedge clk) begin
         if (rst) begin
            r_val <= '0;
         end else if (w_commit && (w_cm_idx == 4'(gi))) begin
            r_val <= w_merged;
         end
      end

      assign w_cfg_flat[gi*DATA_W +: DATA_W] = r_val;
   end

   assign cfg_regs  = w_cfg_flat;
   assign cfg_start = r_cfg_start;

   // AW/W holders: fill independently, both drain on commit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aw_full <= 1'b0;
         r_aw_idx  <= '0;
         r_w_full  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
      end else if (w_commit) begin
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_idx  <= s_axi_aw_addr[ADDR_LSB +: 4];
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_w_data <= s_axi_w_data;
            r_w_strb <= s_axi_w_strb;
         end
      end
   end

   // Write response and start pulse, raised the edge after commit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_b_valid   <= 1'b0;
         r_b_resp    <= RESP_OK;
         r_cfg_start <= 1'b0;
      end else begin
         r_cfg_start <= w_start_hit;
         if (w_commit) begin
            r_b_valid <= 1'b1;
            r_b_resp  <= w_cm_rw ? RESP_OK : RESP_ERR;
         end else if (r_b_valid && s_axi_b_ready) begin
            r_b_valid <= 1'b0;
         end
      end
   end

   assign s_axi_b_valid = r_b_valid;
   assign s_axi_b_resp  = r_b_resp;

   // Read decode from pre-commit register values and live status
   always_comb begin
      w_rd_data = '0;
      w_rd_resp = RESP_ERR;
      if (w_ar_idx < ID_IDX) begin
         w_rd_data = w_cfg_flat[int'(w_ar_idx)*DATA_W +: DATA_W];
         w_rd_resp = RESP_OK;
      end else if (w_ar_idx == ID_IDX) begin
         w_rd_data = DATA_W'(ID_VALUE);
         w_rd_resp = RESP_OK;
      end else if (w_ar_idx == STAT_IDX) begin
         w_rd_data = status_in;
         w_rd_resp = RESP_OK;
      end
   end

   // Read data channel: capture on AR accept, hold until R handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         r_r_valid <= 1'b0;
         r_r_data  <= '0;
         r_r_resp  <= RESP_OK;
      end else if (w_ar_hs) begin
         r_r_valid <= 1'b1;
         r_r_data  <= w_rd_data;
         r_r_resp  <= w_rd_resp;
      end else if (r_r_valid && s_axi_r_ready) begin
         r_r_valid <= 1'b0;
      end
   end

   assign s_axi_r_valid = r_r_valid;
   assign s_axi_r_data  = r_r_data;
   assign s_axi_r_resp  = r_r_resp;

endmodule

// File: tb/tb_axil_cfg_regfile.sv
// Directed testbench for axil_cfg_regfile (NUM_REGS=4, DATA_W=32).
module tb_axil_cfg_regfile;

   localparam int NR = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [31:0]     s_axi_aw_addr = '0;
   logic            s_axi_aw_valid = 1'b0;
   logic            s_axi_aw_ready;
   logic [DW-1:0]   s_axi_w_data = '0;
   logic [DW/8-1:0] s_axi_w_strb = '0;
   logic            s_axi_w_valid = 1'b0;
   logic            s_axi_w_ready;
   logic [1:0]      s_axi_b_resp;
   logic            s_axi_b_valid;
   logic            s_axi_b_ready = 1'b0;
   logic [31:0]     s_axi_ar_addr = '0;
   logic            s_axi_ar_valid = 1'b0;
   logic            s_axi_ar_ready;
   logic [DW-1:0]   s_axi_r_data;
   logic [1:0]      s_axi_r_resp;
   logic            s_axi_r_valid;
   logic            s_axi_r_ready = 1'b0;
   logic [NR*DW-1:0] cfg_regs;
   logic            cfg_start;
   logic [DW-1:0]   status_in = '0;

   int total = 0;
   int bad   = 0;
   int start_cnt = 0;

   axil_cfg_regfile #(.NUM_REGS(NR), .DATA_W(DW), .ID_VALUE(32'hCAFEBABE)) dut (
      .clk(clk), .rst(rst),
      .s_axi_aw_addr(s_axi_aw_addr), .s_axi_aw_valid(s_axi_aw_valid), .s_axi_aw_ready(s_axi_aw_ready),
      .s_axi_w_data(s_axi_w_data), .s_axi_w_strb(s_axi_w_strb),
      .s_axi_w_valid(s_axi_w_valid), .s_axi_w_ready(s_axi_w_ready),
      .s_axi_b_resp(s_axi_b_resp), .s_axi_b_valid(s_axi_b_valid), .s_axi_b_ready(s_axi_b_ready),
      .s_axi_ar_addr(s_axi_ar_addr), .s_axi_ar_valid(s_axi_ar_valid), .s_axi_ar_ready(s_axi_ar_ready),
      .s_axi_r_data(s_axi_r_data), .s_axi_r_resp(s_axi_r_resp),
      .s_axi_r_valid(s_axi_r_valid), .s_axi_r_ready(s_axi_r_ready),
      .cfg_regs(cfg_regs), .cfg_start(cfg_start), .status_in(status_in)
   );

   always #5 clk = ~clk;

   // Count cycles in which the start strobe is high
   always @(negedge clk) begin
      if (cfg_start) start_cnt <= start_cnt + 1;
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] reg_of(input int i);
      return cfg_regs[i*DW +: DW];
   endfunction

   // AW and W presented together; returns the write response
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      int n = 0;
      @(negedge clk);
      s_axi_aw_addr = addr; s_axi_aw_valid = 1'b1;
      s_axi_w_data = data;  s_axi_w_strb = strb; s_axi_w_valid = 1'b1;
      while (!(s_axi_aw_ready && s_axi_w_ready) && n < 20) begin
         @(negedge clk); n++;
      end
      check_val("wr_ready_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      s_axi_aw_valid = 1'b0; s_axi_w_valid = 1'b0;
      check_val("wr_bvalid_lat", s_axi_b_valid, 1'b1);
      resp = s_axi_b_resp;
      s_axi_b_ready = 1'b1;
      @(negedge clk);
      s_axi_b_ready = 1'b0;
      check_val("wr_bvalid_drop", s_axi_b_valid, 1'b0);
      $display("write addr=%h data=%h strb=%h resp=%0d", addr, data, strb, resp);
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      @(negedge clk);
      s_axi_ar_addr = addr; s_axi_ar_valid = 1'b1;
      while (!s_axi_ar_ready && n < 20) begin
         @(negedge clk); n++;
      end
      check_val("rd_ready_wait", 32'(n < 20), 32'd1);
      @(negedge clk);
      s_axi_ar_valid = 1'b0;
      check_val("rd_rvalid_lat", s_axi_r_valid, 1'b1);
      data = s_axi_r_data; resp = s_axi_r_resp;
      s_axi_r_ready = 1'b1;
      @(negedge clk);
      s_axi_r_ready = 1'b0;
      check_val("rd_rvalid_drop", s_axi_r_valid, 1'b0);
      $display("read  addr=%h data=%h resp=%0d", addr, data, resp);
   endtask

   initial begin
      logic [1:0]  resp;
      logic [31:0] data;
      int          s0;

      // Reset state
      @(negedge clk);
      check_val("rst_aw_ready", s_axi_aw_ready, 1'b0);
      check_val("rst_w_ready", s_axi_w_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_cfg", cfg_regs, '0);
      check_val("post_rst_bvalid", s_axi_b_valid, 1'b0);
      check_val("post_rst_rvalid", s_axi_r_valid, 1'b0);
      check_val("post_rst_ar_ready", s_axi_ar_ready, 1'b1);
      check_val("post_rst_aw_ready", s_axi_aw_ready, 1'b1);
      check_val("post_rst_start", cfg_start, 1'b0);

      // AW+W together into reg1
      do_write(32'h4, 32'h0000_0010, 4'hF, resp);
      check_val("w1_resp", resp, 2'b00);
      check_val("w1_reg1", reg_of(1), 32'h10);

      // W three cycles ahead of AW, then B backpressure
      @(negedge clk);
      s_axi_w_data = 32'hAABBCCDD; s_axi_w_strb = 4'h5; s_axi_w_valid = 1'b1;
      check_val("w2_w_ready", s_axi_w_ready, 1'b1);
      @(negedge clk);
      s_axi_w_valid = 1'b0;
      check_val("w2_w_held", s_axi_w_ready, 1'b0);
      @(negedge clk);
      @(negedge clk);
      s_axi_aw_addr = 32'h8; s_axi_aw_valid = 1'b1;
      check_val("w2_aw_ready", s_axi_aw_ready, 1'b1);
      @(negedge clk);
      s_axi_aw_valid = 1'b0;
      check_val("w2_no_b_yet", s_axi_b_valid, 1'b0);
      @(negedge clk);
      check_val("w2_resp", s_axi_b_resp, 2'b00);
      for (int i = 0; i < 5; i++) begin
         check_val("w2_b_hold", s_axi_b_valid, 1'b1);
         check_val("w2_aw_blocked", s_axi_aw_ready, 1'b0);
         check_val("w2_w_blocked", s_axi_w_ready, 1'b0);
         @(negedge clk);
      end
      s_axi_b_ready = 1'b1;
      @(negedge clk);
      s_axi_b_ready = 1'b0;
      check_val("w2_b_drop", s_axi_b_valid, 1'b0);
      check_val("w2_reg2", reg_of(2), 32'h00BB00DD);
      $display("write addr=00000008 data=aabbccdd strb=5 (W early, B stalled)");

      // Start strobe via reg0
      s0 = start_cnt;
      do_write(32'h0, 32'h0000_0103, 4'hF, resp);
      repeat (3) @(negedge clk);
      check_val("start_pulses", start_cnt - s0, 1);
      check_val("start_low", cfg_start, 1'b0);
      do_read(32'h0, data, resp);
      check_val("r0_data", data, 32'h0000_0102);
      check_val("r0_resp", resp, 2'b00);

      // Partial strobes on reg3
      do_write(32'hC, 32'hFFFF_FFFF, 4'hF, resp);
      do_write(32'hC, 32'h1122_3344, 4'hA, resp);
      check_val("w3_reg3", reg_of(3), 32'h11FF33FF);

      // ID, status and unmapped reads
      status_in = 32'h1234_5678;
      do_read(32'h10, data, resp);
      check_val("id_data", data, 32'hCAFEBABE);
      check_val("id_resp", resp, 2'b00);
      do_read(32'h14, data, resp);
      check_val("st_data", data, 32'h1234_5678);
      check_val("st_resp", resp, 2'b00);
      do_read(32'h1C, data, resp);
      check_val("unm_data", data, 32'h0);
      check_val("unm_resp", resp, 2'b10);

      // Writes to read-only / unmapped indices
      do_write(32'h10, 32'hFFFF_FFFF, 4'hF, resp);
      check_val("wid_resp", resp, 2'b10);
      do_write(32'h1C, 32'hFFFF_FFFF, 4'hF, resp);
      check_val("wunm_resp", resp, 2'b10);
      check_val("ro_cfg_kept", cfg_regs, {32'h11FF33FF, 32'h00BB00DD, 32'h10, 32'h102});
      do_read(32'h10, data, resp);
      check_val("id_kept", data, 32'hCAFEBABE);

      // R backpressure with status changing underneath
      @(negedge clk);
      s_axi_ar_addr = 32'h14; s_axi_ar_valid = 1'b1;
      @(negedge clk);
      s_axi_ar_valid = 1'b0;
      status_in = 32'hDEAD_0000;
      for (int i = 0; i < 4; i++) begin
         check_val("rbp_valid", s_axi_r_valid, 1'b1);
         check_val("rbp_data", s_axi_r_data, 32'h1234_5678);
         check_val("rbp_ar_ready", s_axi_ar_ready, 1'b0);
         @(negedge clk);
      end
      s_axi_r_ready = 1'b1;
      @(negedge clk);
      s_axi_r_ready = 1'b0;
      check_val("rbp_drop", s_axi_r_valid, 1'b0);
      $display("read  addr=00000014 data=12345678 (R stalled 4 cycles)");

      // Upper address bits alias onto reg1
      do_write(32'h0000_0104, 32'h55, 4'hF, resp);
      check_val("alias_reg1", reg_of(1), 32'h55);

      // Read and write of reg1 on the same edge: read sees old value
      @(negedge clk);
      s_axi_aw_addr = 32'h4; s_axi_aw_valid = 1'b1;
      s_axi_w_data = 32'h77; s_axi_w_strb = 4'hF; s_axi_w_valid = 1'b1;
      s_axi_ar_addr = 32'h4; s_axi_ar_valid = 1'b1;
      @(negedge clk);
      s_axi_aw_valid = 1'b0; s_axi_w_valid = 1'b0; s_axi_ar_valid = 1'b0;
      check_val("rw_same_rdata", s_axi_r_data, 32'h55);
      check_val("rw_same_bvalid", s_axi_b_valid, 1'b1);
      check_val("rw_same_reg1", reg_of(1), 32'h77);
      s_axi_b_ready = 1'b1; s_axi_r_ready = 1'b1;
      @(negedge clk);
      s_axi_b_ready = 1'b0; s_axi_r_ready = 1'b0;
      $display("write+read addr=00000004 wdata=77 rdata=%h", 32'h55);

      // Reset with AW held and W not yet sent
      s0 = start_cnt;
      @(negedge clk);
      s_axi_aw_addr = 32'h0; s_axi_aw_valid = 1'b1;
      @(negedge clk);
      s_axi_aw_valid = 1'b0;
      check_val("mid_aw_held", s_axi_aw_ready, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("mid_rst_cfg", cfg_regs, '0);
      check_val("mid_rst_bvalid", s_axi_b_valid, 1'b0);
      s_axi_w_data = 32'h1; s_axi_w_strb = 4'hF; s_axi_w_valid = 1'b1;
      @(negedge clk);
      s_axi_w_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_val("mid_no_commit", s_axi_b_valid, 1'b0);
      check_val("mid_no_start", start_cnt - s0, 0);
      check_val("mid_reg0", reg_of(0), 32'h0);
      $display("reset mid-transaction: aw held, w later");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
